// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush outranks push and pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  storage [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = storage[rd_ptr];
    // A pop frees the slot being written, so push is legal when full with pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= wr_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads imem and feeds decode via a prefetch FIFO.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_wr;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = (state == RUN) & ~redirect_valid & (~fifo_full | pop);
    assign imem_en   = push;
    assign imem_addr = fetch_pc;
    assign fifo_wr   = '{pc: fetch_pc, instr: imem_data};
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (fifo_wr),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= fetch_en ? RUN : IDLE;
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
            end else if (push) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

    count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl against a PC/occupancy reference model.
module tb_ifetch_ctrl;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] imem_addr [2];
    logic        imem_en   [2];
    logic [31:0] imem_data [2];
    logic        out_valid [2];
    logic [31:0] out_instr [2];
    logic [31:0] out_pc    [2];

    int unsigned n_checks;
    int unsigned n_errors;

    // Model state: FIFO holds consecutive PCs ending just below m_pc.
    logic [31:0] m_pc    [2];
    int unsigned m_cnt   [2];
    bit          m_run   [2];
    bit          m_clean [2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rst_pc(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    assign imem_data[0] = mem_word(imem_addr[0]);
    assign imem_data[1] = mem_word(imem_addr[1]);

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr[0]),
        .imem_en        (imem_en[0]),
        .imem_data      (imem_data[0]),
        .out_valid      (out_valid[0]),
        .out_ready      (out_ready),
        .out_instr      (out_instr[0]),
        .out_pc         (out_pc[0])
    );

    ifetch_ctrl #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (DEPTH)
    ) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr[1]),
        .imem_en        (imem_en[1]),
        .imem_data      (imem_data[1]),
        .out_valid      (out_valid[1]),
        .out_ready      (out_ready),
        .out_instr      (out_instr[1]),
        .out_pc         (out_pc[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit fe, input bit rv,
                        input logic [31:0] rpc, input bit rdy);
        logic [31:0] head_pc;
        bit          e_valid;
        bit          e_pop;
        bit          e_push;
        @(negedge clk);
        rst_n          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        for (int i = 0; i < 2; i++) begin
            e_valid = (m_cnt[i] != 0);
            e_pop   = e_valid & rdy;
            e_push  = m_run[i] & !rv & ((m_cnt[i] < DEPTH) | e_pop);
            check($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(e_valid));
            check($sformatf("imem_en%0d", i), 32'(imem_en[i]), 32'(e_push));
            check($sformatf("imem_addr%0d", i), imem_addr[i], m_pc[i]);
            if (e_valid) begin
                head_pc = m_pc[i] - 32'(4 * m_cnt[i]);
                check($sformatf("out_pc%0d", i), out_pc[i], head_pc);
                check($sformatf("out_instr%0d", i), out_instr[i], mem_word(head_pc));
            end else if (m_clean[i]) begin
                check($sformatf("rst_pc%0d", i), out_pc[i], 32'h0);
                check($sformatf("rst_instr%0d", i), out_instr[i], 32'h0);
            end
            // State as it will be after the coming rising edge.
            if (!rst) begin
                m_pc[i]    = rst_pc(i);
                m_cnt[i]   = 0;
                m_run[i]   = 1'b0;
                m_clean[i] = 1'b1;
            end else begin
                if (rv) begin
                    m_cnt[i] = 0;
                    m_pc[i]  = rpc & 32'hFFFF_FFFC;
                end else begin
                    if (e_pop)  m_cnt[i] = m_cnt[i] - 1;
                    if (e_push) begin
                        m_cnt[i]   = m_cnt[i] + 1;
                        m_pc[i]    = m_pc[i] + 32'd4;
                        m_clean[i] = 1'b0;
                    end
                end
                m_run[i] = fe;
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = rst_pc(i);
            m_cnt[i]   = 0;
            m_run[i]   = 1'b0;
            m_clean[i] = 1'b1;
        end

        // Reset, then stream with decode always ready.
        repeat (2) step(0, 0, 0, 32'h0, 0);
        repeat (6) step(1, 1, 0, 32'h0, 1);
        // Back-pressure then release.
        repeat (5) step(1, 1, 0, 32'h0, 0);
        repeat (3) step(1, 1, 0, 32'h0, 1);
        // Redirect with two buffered entries and decode ready.
        repeat (2) step(1, 1, 0, 32'h0, 0);
        step(1, 1, 1, 32'h0000_0042, 1);
        repeat (3) step(1, 1, 0, 32'h0, 1);
        // Drop fetch_en, drain, then resume from the frozen PC.
        step(1, 1, 0, 32'h0, 1);
        repeat (4) step(1, 0, 0, 32'h0, 1);
        repeat (3) step(1, 1, 0, 32'h0, 1);
        // Reset mid-stream while full, with a coincident redirect.
        repeat (3) step(1, 1, 0, 32'h0, 0);
        step(0, 1, 1, 32'h0000_0100, 0);
        repeat (4) step(1, 1, 0, 32'h0, 1);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(63) != 0),
                 ($urandom_range(9) < 8),
                 ($urandom_range(11) == 0),
                 $urandom,
                 ($urandom_range(9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the PC and drives the combinational instruction-memory read port (imem_addr/imem_en/imem_data).
- Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush buffered instructions and restart fetch at a new PC.
- Sits between the instruction memory and the decode stage of the 32-bit RISC-V core.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 2, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- fetch_en  in  1  enables fetching; 0 stalls fetch without flushing.
- redirect_valid  in  1  single-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0.
- imem_addr  out  32  byte address to instruction memory; equals the current fetch PC.
- imem_en  out  1  read strobe; high in any cycle where the returned word is captured.
- imem_data  in  32  combinational read data for imem_addr, valid in the same cycle.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of the FIFO head.

Behaviour:
- States: IDLE, RUN.
  - IDLE -> RUN on a cycle with fetch_en=1.
  - RUN -> IDLE on a cycle with fetch_en=0.
  - Reset forces IDLE.
- Reset (rst_n=0 sampled at an edge):
  - fetch_pc=RESET_PC; FIFO count=0; head and tail pointers=0; storage cleared.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, imem_en=0, imem_addr=RESET_PC.
  - Reset overrides redirect and handshake in the same cycle.
- pop = out_valid & out_ready.
- push = state==RUN & !redirect_valid & (count<DEPTH | pop). Applies to the current cycle only.
- imem_en = push, combinational. imem_addr = fetch_pc, registered.
- On push:
  - {imem_data, fetch_pc} is written at the tail.
  - fetch_pc <= fetch_pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Simultaneous push and pop when full: allowed; count stays the same.
- Latency:
  - fetch_en sampled high at edge k gives RUN during cycle k..k+1 and the first push at edge k+1.
  - out_valid=1 from cycle k+1 onward, i.e. 2 edges after fetch_en.
  - Sustained throughput: 1 instruction per cycle while out_ready=1.
- out_valid = (count!=0). out_instr and out_pc come from the head entry with no extra register stage.
- Back-pressure: when the FIFO is full and out_ready=0, there is no push, fetch_pc holds and imem_en=0.
- Redirect (redirect_valid=1 at edge, in either state):
  - FIFO is flushed: count=0, pointers=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - A pop in the same cycle is not counted: decode discards it, since it ignores the handshake during redirect.
  - No push occurs in the redirect cycle.
  - out_valid=0 on the following cycle; the first new-path push happens on that cycle if in RUN.
  - Back-to-back redirects: the last one wins.
- fetch_en=0:
  - Pushes stop after the current cycle.
  - FIFO contents remain and may still drain via out_ready.
  - fetch_pc holds.
- Empty FIFO with out_ready=1: no pop; count never underflows. Full FIFO: count never exceeds DEPTH.
- No combinational path from out_ready to out_valid.
  - out_ready does reach imem_en, through the full-with-pop case.

Decomposition:
- Package ifetch_pkg: state encoding (IDLE=1'b0, RUN=1'b1), PC_STEP=4, NOP_INSTR=32'h0000_0013, default RESET_PC.
- Sub-module fetch_fifo (DEPTH x 64-bit {pc,instr}).
  - Ports: push, pop, flush; full and empty flags; head data; count.
  - Flush has priority over push and pop.
- ifetch_ctrl keeps the FSM, fetch_pc register and push/pop logic.

Test Plan:
- Reset then fetch_en=1, out_ready=1, with memory words W0..W3 at addresses 0x0..0xC.
  - Expected: out_valid rises 2 edges after fetch_en.
  - Expected: out_pc sequence 0x0,0x4,0x8,0xC with out_instr W0..W3, one per cycle.
- out_ready=0 for 5 cycles in RUN.
  - Expected: after 2 pushes the FIFO is full, imem_en=0 and imem_addr holds at 0x8.
  - Expected: releasing out_ready resumes pops at pc 0x0 with no skipped or duplicated PCs.
- Redirect with redirect_pc=0x0000_0042 while the FIFO holds 2 entries and out_ready=1.
  - Expected: next cycle out_valid=0.
  - Expected: the following cycle out_pc=0x40 and out_instr=mem[0x40].
- Wrap-around: RESET_PC=32'hFFFF_FFF8, run 3 pushes.
  - Expected: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- fetch_en dropped after 1 push, out_ready=1.
  - Expected: the buffered entries drain, then out_valid=0, imem_en=0, fetch_pc frozen.
  - Expected: re-asserting fetch_en continues from the frozen PC.
- rst_n=0 for one edge mid-stream with the FIFO full and redirect_valid=1 in the same cycle.
  - Expected: out_valid=0, imem_addr=RESET_PC, state IDLE; the redirect is ignored.
